// File: rtl/knn_host_sequencer.sv
`default_nettype none
// ============================================================================
// knn_host_sequencer : host register bridge that loads a query vector and k,
//                      starts the top-k core, guards it with a timeout and
//                      latches the result indices for readback.
// Revision 1.0
// ============================================================================
module knn_host_sequencer #(
  parameter  int DIM     = 4,
  parameter  int WIDTH   = 16,
  parameter  int K_MAX   = 8,
  parameter  int IDX_W   = 8,
  parameter  int ADDR_W  = 8,
  parameter  int TIMEOUT = 1000,
  localparam int KW      = $clog2(K_MAX + 1)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          host_wr_in,
  input  logic                          host_rd_in,
  input  logic [ADDR_W-1:0]             host_addr_in,
  input  logic [WIDTH-1:0]              host_wdata_in,
  output logic [WIDTH-1:0]              host_rdata_out,
  output logic                          host_rvalid_out,
  output logic [DIM-1:0][WIDTH-1:0]     query_out,
  output logic [KW-1:0]                 k_out,
  output logic                          start_out,
  input  logic                          core_valid_in,
  input  logic [K_MAX-1:0][IDX_W-1:0]   core_result_in
);

  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam int Q_BASE = 2;
  localparam int R_BASE = 2 + DIM;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [CW-1:0]     C_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]     C_SAT    = CW'(TIMEOUT);
  localparam logic [KW-1:0]     C_KMAX   = KW'(K_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [DIM-1:0][WIDTH-1:0]      query_q, query_d;
  logic [K_MAX-1:0][IDX_W-1:0]    result_q, result_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0]               rdata_q, rdata_d;
  logic                           rvalid_q, rvalid_d;

  logic                           busy;
  logic                           ctrl_wr;
  logic                           k_ok;
  logic                           timeout_hit;
  logic [KW-1:0]                  k_wr;

  assign k_wr        = host_wdata_in[KW-1:0];
  assign k_ok        = (k_wr != '0) && (k_wr <= C_KMAX);
  assign ctrl_wr     = host_wr_in && (host_addr_in == A_CTRL) && (state_q == S_IDLE);
  assign timeout_hit = (cnt_q == C_LAST);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_wr && k_ok) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (core_valid_in || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_out = (state_q == S_START);
    busy      = (state_q != S_IDLE);
  end

  // Flags are cleared on the accepting write so STATUS is clean during START.
  always_comb begin
    k_d      = k_q;
    query_d  = query_q;
    result_d = result_q;
    done_d   = done_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    if (ctrl_wr) begin
      if (k_ok) begin
        k_d     = k_wr;
        done_d  = 1'b0;
        error_d = 1'b0;
      end else begin
        error_d = 1'b1;
      end
    end
    if (host_wr_in && !busy) begin
      for (int i = 0; i < DIM; i++) begin
        if (host_addr_in == ADDR_W'(Q_BASE + i)) query_d[i] = host_wdata_in;
      end
    end
    if (state_q == S_START) begin
      cnt_d   = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (state_q == S_WAIT) begin
      if (core_valid_in) begin
        result_d = core_result_in;
        done_d   = 1'b1;
        error_d  = 1'b0;
      end else if (timeout_hit) begin
        error_d = 1'b1;
      end else if (cnt_q != C_SAT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Reads sample current register contents, so a same-cycle write is not seen.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = host_rd_in;
    if (host_rd_in) begin
      if (host_addr_in == A_STATUS) rdata_d = WIDTH'({error_q, done_q, busy});
      for (int i = 0; i < DIM; i++) begin
        if (host_addr_in == ADDR_W'(Q_BASE + i)) rdata_d = query_q[i];
      end
      for (int j = 0; j < K_MAX; j++) begin
        if (host_addr_in == ADDR_W'(R_BASE + j)) rdata_d = WIDTH'(result_q[j]);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      k_q      <= '0;
      query_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      query_q  <= query_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign host_rdata_out  = rdata_q;
  assign host_rvalid_out = rvalid_q;
  assign query_out       = query_q;
  assign k_out           = k_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_host_sequencer.sv
`default_nettype none
// ============================================================================
// tb_knn_host_sequencer : directed and randomized bench for the knn host
//                         sequencer against a timestamp-based register model.
// Revision 1.0
// ============================================================================
module tb_knn_host_sequencer;

  localparam int DIM      = 4;
  localparam int WIDTH    = 16;
  localparam int K_MAX    = 8;
  localparam int IDX_W    = 8;
  localparam int ADDR_W   = 8;
  localparam int TIMEOUT  = 20;
  localparam int KW       = $clog2(K_MAX + 1);
  localparam int RES_BASE = 2 + DIM;
  localparam int ADDR_END = 2 + DIM + K_MAX;

  typedef logic [IDX_W-1:0] res_t [K_MAX];

  logic                        clk_in = 1'b0;
  logic                        rst_in = 1'b1;
  logic                        host_wr_in = 1'b0;
  logic                        host_rd_in = 1'b0;
  logic [ADDR_W-1:0]           host_addr_in = '0;
  logic [WIDTH-1:0]            host_wdata_in = '0;
  logic [WIDTH-1:0]            host_rdata_out;
  logic                        host_rvalid_out;
  logic [DIM-1:0][WIDTH-1:0]   query_out;
  logic [KW-1:0]               k_out;
  logic                        start_out;
  logic                        core_valid_in = 1'b0;
  logic [K_MAX-1:0][IDX_W-1:0] core_result_in = '0;

  knn_host_sequencer #(
    .DIM(DIM), .WIDTH(WIDTH), .K_MAX(K_MAX), .IDX_W(IDX_W),
    .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .host_wr_in(host_wr_in), .host_rd_in(host_rd_in),
    .host_addr_in(host_addr_in), .host_wdata_in(host_wdata_in),
    .host_rdata_out(host_rdata_out), .host_rvalid_out(host_rvalid_out),
    .query_out(query_out), .k_out(k_out), .start_out(start_out),
    .core_valid_in(core_valid_in), .core_result_in(core_result_in)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int now      = 0;
  int n_start_seen = 0;

  // Reference model: a run is busy from its start cycle m_s through m_s+TIMEOUT.
  logic [WIDTH-1:0] m_query [DIM];
  logic [IDX_W-1:0] m_res [K_MAX];
  int  m_k;
  bit  m_run, m_done, m_err;
  int  m_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DIM; i++) m_query[i] = '0;
    for (int j = 0; j < K_MAX; j++) m_res[j] = '0;
    m_k = 0; m_run = 0; m_done = 0; m_err = 0; m_s = -1000;
  endfunction

  function automatic void sync();
    if (m_run && now > m_s + TIMEOUT) begin
      m_run = 0;
      m_err = 1;
    end
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    if (a == 1) return WIDTH'({m_err, m_done, m_run});
    if (a >= 2 && a < 2 + DIM) return m_query[a-2];
    if (a >= RES_BASE && a < RES_BASE + K_MAX) return WIDTH'(m_res[a-RES_BASE]);
    return '0;
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
    now++;
    if (start_out) n_start_seen++;
  endtask

  task automatic check_outputs(input bit exp_rv);
    sync();
    chk("start_out", start_out, (m_run && now == m_s));
    chk("k_out", k_out, m_k);
    for (int i = 0; i < DIM; i++) chk($sformatf("query_out[%0d]", i), query_out[i], m_query[i]);
    chk("rvalid", host_rvalid_out, exp_rv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_outputs(0);
    end
  endtask

  task automatic rd(input int a, output logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] e;
    sync();
    e = exp_rd(a);
    host_rd_in = 1; host_addr_in = ADDR_W'(a);
    cyc();
    host_rd_in = 0;
    v = host_rdata_out;
    chk($sformatf("rd[%0d]", a), v, e);
    check_outputs(1);
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input bit also_rd);
    bit acc, bad, qw;
    int k;
    logic [WIDTH-1:0] e;
    sync();
    k   = int'(d[KW-1:0]);
    acc = (a == 0) && !m_run && k >= 1 && k <= K_MAX;
    bad = (a == 0) && !m_run && !(k >= 1 && k <= K_MAX);
    qw  = !m_run && a >= 2 && a < 2 + DIM;
    e   = exp_rd(a);
    host_wr_in = 1; host_rd_in = also_rd; host_addr_in = ADDR_W'(a); host_wdata_in = d;
    cyc();
    host_wr_in = 0; host_rd_in = 0;
    if (also_rd) chk($sformatf("rdwr[%0d]", a), host_rdata_out, e);
    if (acc) begin m_k = k; m_run = 1; m_s = now; m_done = 0; m_err = 0; end
    if (bad) m_err = 1;
    if (qw) m_query[a-2] = d;
    check_outputs(also_rd);
  endtask

  task automatic pv(input res_t r);
    bit acc;
    sync();
    acc = m_run && now >= m_s + 1;
    core_valid_in = 1;
    for (int j = 0; j < K_MAX; j++) core_result_in[j] = r[j];
    cyc();
    core_valid_in = 0;
    for (int j = 0; j < K_MAX; j++) core_result_in[j] = IDX_W'($urandom);
    if (acc) begin
      for (int j = 0; j < K_MAX; j++) m_res[j] = r[j];
      m_done = 1; m_err = 0; m_run = 0;
    end
    check_outputs(0);
  endtask

  task automatic do_reset();
    rst_in = 1;
    #1;
    model_reset();
    chk("rst_start", start_out, 0);
    chk("rst_k", k_out, 0);
    chk("rst_rvalid", host_rvalid_out, 0);
    chk("rst_rdata", host_rdata_out, 0);
    chk("rst_query", query_out, 0);
    cyc();
    rst_in = 0;
    check_outputs(0);
  endtask

  task automatic rand_res(output res_t r);
    for (int j = 0; j < K_MAX; j++) r[j] = IDX_W'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] v;
    res_t r;
    int s;
    model_reset();
    repeat (2) cyc();
    rst_in = 0;
    idle(1);

    // Reset, then every address reads zero.
    do_reset();
    for (int a = 0; a <= ADDR_END; a++) begin
      rd(a, v);
      chk("reset_read", v, 0);
    end

    // Query write and readback.
    wr(2, 16'h0011, 0); chk("q0_out", query_out[0], 16'h0011);
    wr(3, 16'h0022, 0); chk("q1_out", query_out[1], 16'h0022);
    wr(4, 16'h0033, 0); chk("q2_out", query_out[2], 16'h0033);
    wr(5, 16'h0044, 0); chk("q3_out", query_out[3], 16'h0044);
    rd(2, v); chk("q0_rd", v, 16'h0011);
    rd(5, v); chk("q3_rd", v, 16'h0044);
    wr(2, 16'h0055, 1);
    rd(2, v); chk("rdwr_after", v, 16'h0055);

    // Bad k values.
    wr(0, 16'd0, 0);
    rd(1, v); chk("badk0_status", v, 4);
    wr(0, 16'(K_MAX + 1), 0);
    rd(1, v); chk("badk9_status", v, 4);
    chk("badk_no_start", n_start_seen, 0);
    chk("badk_k_out", k_out, 0);

    // Normal run: core answers 10 cycles after start.
    wr(0, 16'd4, 0);
    s = now;
    chk("run_start", start_out, 1);
    chk("run_k", k_out, 4);
    rd(1, v); chk("run_status_busy", v, 1);
    idle(s + 10 - now);
    for (int j = 0; j < K_MAX; j++) r[j] = IDX_W'(7 - j);
    pv(r);
    rd(1, v); chk("run_status_done", v, 2);
    rd(RES_BASE, v); chk("run_res0", v, 7);
    rd(RES_BASE + 7, v); chk("run_res7", v, 0);
    chk("run_one_start", n_start_seen, 1);

    // Timeout with an ignored query write.
    wr(0, 16'd3, 0);
    s = now;
    wr(2, 16'hBEEF, 0);
    chk("to_q_ignored", query_out[0], 16'h0055);
    idle(s + TIMEOUT - now);
    rd(1, v); chk("to_status_last", v, 1);
    rd(1, v); chk("to_status_err", v, 4);
    rand_res(r);
    pv(r);
    rd(RES_BASE, v); chk("to_res0_kept", v, 7);
    rd(RES_BASE + 7, v); chk("to_res7_kept", v, 0);

    // Reset during WAIT.
    wr(0, 16'd2, 0);
    idle(3);
    do_reset();
    rd(1, v); chk("rstw_status", v, 0);
    rand_res(r);
    pv(r);
    rd(RES_BASE, v); chk("rstw_res0", v, 0);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rd($urandom_range(0, ADDR_END + 2), v);
        3, 4:    wr($urandom_range(1, ADDR_END + 1), WIDTH'($urandom), $urandom_range(0, 1) == 1);
        5:       wr(0, WIDTH'($urandom), 0);
        6, 7: begin
          rand_res(r);
          pv(r);
        end
        default: idle($urandom_range(1, 8));
      endcase
    end
    idle(TIMEOUT + 2);
    rd(1, v);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
